// File: rtl/lc3b_mem_arbiter_if.sv
// Request/response bundle between the LC-3b I/D requesters, the arbiter and physical memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface lc3b_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [1:0]            d_wmask;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [1:0]            pmem_wmask;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [DATA_WIDTH-1:0] pmem_wdata;
    logic [DATA_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    logic [CNT_WIDTH-1:0]  i_count;
    logic [CNT_WIDTH-1:0]  d_count;

    modport slave (
        input  i_read, i_address,
        input  d_read, d_write, d_wmask, d_address, d_wdata,
        input  pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
        output i_count, d_count
    );

    modport master (
        output i_read, i_address,
        output d_read, d_write, d_wmask, d_address, d_wdata,
        output pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
        input  i_count, d_count
    );
endinterface

// File: rtl/lc3b_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Strobe one cycle after request; response same cycle as pmem_resp; requests held until resp.
module lc3b_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    lc3b_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        s_idle = 2'd0,
        s_inst = 2'd1,
        s_data = 2'd2
    } state_t;

    state_t                state;
    logic                  last_grant_data;
    logic [ADDR_WIDTH-1:0] lat_address;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [1:0]            lat_wmask;
    logic                  rd_q;
    logic                  wr_q;
    logic [CNT_WIDTH-1:0]  i_cnt;
    logic [CNT_WIDTH-1:0]  d_cnt;

    logic i_req;
    logic d_req;
    logic grant_inst;
    logic grant_data;

    assign i_req      = bus.i_read;
    assign d_req      = bus.d_read | bus.d_write;
    // On a tie the port that did not win last time goes first.
    assign grant_inst = i_req & (~d_req | last_grant_data);
    assign grant_data = d_req & ~grant_inst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= s_idle;
            last_grant_data <= 1'b1;
            lat_address     <= '0;
            lat_wdata       <= '0;
            lat_wmask       <= 2'b11;
            rd_q            <= 1'b0;
            wr_q            <= 1'b0;
            i_cnt           <= '0;
            d_cnt           <= '0;
        end else begin
            case (state)
                s_idle: begin
                    if (grant_inst) begin
                        lat_address     <= bus.i_address;
                        lat_wdata       <= '0;
                        lat_wmask       <= 2'b11;
                        rd_q            <= 1'b1;
                        wr_q            <= 1'b0;
                        last_grant_data <= 1'b0;
                        state           <= s_inst;
                    end else if (grant_data) begin
                        lat_address     <= bus.d_address;
                        lat_wdata       <= bus.d_wdata;
                        lat_wmask       <= bus.d_wmask;
                        rd_q            <= ~bus.d_write;
                        wr_q            <= bus.d_write;
                        last_grant_data <= 1'b1;
                        state           <= s_data;
                    end
                end
                s_inst: begin
                    if (bus.pmem_resp) begin
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                        state <= s_idle;
                        if (i_cnt != '1) begin
                            i_cnt <= i_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                s_data: begin
                    if (bus.pmem_resp) begin
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                        state <= s_idle;
                        if (d_cnt != '1) begin
                            d_cnt <= d_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                    state <= s_idle;
                end
            endcase
        end
    end

    assign bus.pmem_read    = rd_q;
    assign bus.pmem_write   = wr_q;
    assign bus.pmem_address = lat_address;
    assign bus.pmem_wdata   = lat_wdata;
    assign bus.pmem_wmask   = lat_wmask;

    // Responses are steered combinationally so the owner sees completion in the pmem_resp cycle.
    assign bus.i_resp  = (state == s_inst) & bus.pmem_resp;
    assign bus.d_resp  = (state == s_data) & bus.pmem_resp;
    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;

    assign bus.i_count = i_cnt;
    assign bus.d_count = d_cnt;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter: vector table, corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_lc3b_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic reset;

    lc3b_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    lc3b_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_read     = 1'b0;
        bus.i_address  = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_wmask    = 2'b11;
        bus.d_address  = '0;
        bus.d_wdata    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic int sat_inc(input int c);
        return (c >= CMAX) ? c : c + 1;
    endfunction

    typedef struct {
        logic        i_read;
        logic        d_read;
        logic        d_write;
        logic [1:0]  wmask;
        logic [15:0] i_addr;
        logic [15:0] d_addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [1:0]  exp_mask;
        logic        exp_owner_d;
    } vec_t;

    vec_t vecs[8];

    // Reference model state (transaction level)
    logic        m_busy;
    logic        m_owner_d;
    logic        m_last_d;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [1:0]  m_mask;
    logic        m_write;
    int          m_icnt;
    int          m_dcnt;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_i;
        int exp_d;
        int owners[$];
        int resp_cycle;
        int wcnt;
        int n_resp;
        logic prev_strobe;
        logic i_act, d_act, i_got, d_got;
        int mem_wait;

        reset = 1'b0;
        idle_inputs();

        // ---------------- table-driven transactions ----------------
        //            ir d  w  mask   iaddr     daddr     wdata     rdata     rd wr addr      wdata     mask  own_d
        vecs[0] = '{1, 0, 0, 2'b00, 16'h0010, 16'h1111, 16'h5555, 16'h1234, 1, 0, 16'h0010, 16'h0000, 2'b11, 0};
        vecs[1] = '{0, 0, 1, 2'b10, 16'h2222, 16'h0101, 16'hAB00, 16'h0000, 0, 1, 16'h0101, 16'hAB00, 2'b10, 1};
        vecs[2] = '{1, 1, 0, 2'b11, 16'h0300, 16'h0400, 16'h0000, 16'hBEEF, 1, 0, 16'h0300, 16'h0000, 2'b11, 0};
        vecs[3] = '{1, 1, 0, 2'b01, 16'h0500, 16'h0600, 16'h0000, 16'hCAFE, 1, 0, 16'h0600, 16'h0000, 2'b01, 1};
        vecs[4] = '{0, 1, 1, 2'b11, 16'h0000, 16'h0700, 16'h1357, 16'h0000, 0, 1, 16'h0700, 16'h1357, 2'b11, 1};
        vecs[5] = '{1, 0, 1, 2'b01, 16'h0800, 16'h0900, 16'h00CD, 16'h4321, 1, 0, 16'h0800, 16'h0000, 2'b11, 0};
        vecs[6] = '{1, 0, 1, 2'b10, 16'h0A00, 16'h0B00, 16'hEF00, 16'h0000, 0, 1, 16'h0B00, 16'hEF00, 2'b10, 1};
        vecs[7] = '{0, 1, 0, 2'b11, 16'h0000, 16'hFFFF, 16'h0000, 16'h0F0F, 1, 0, 16'hFFFF, 16'h0000, 2'b11, 1};

        do_reset();
        @(negedge clk);
        chk("reset_pmem_read", bus.pmem_read, 1'b0);
        chk("reset_pmem_write", bus.pmem_write, 1'b0);
        chk("reset_wmask", bus.pmem_wmask, 2'b11);
        chk("reset_i_count", bus.i_count, 0);
        chk("reset_d_count", bus.d_count, 0);
        chk("reset_resps", {bus.i_resp, bus.d_resp}, 2'b00);
        step();

        exp_i = 0;
        exp_d = 0;
        for (int k = 0; k < 8; k++) begin
            bus.i_read    = vecs[k].i_read;
            bus.d_read    = vecs[k].d_read;
            bus.d_write   = vecs[k].d_write;
            bus.d_wmask   = vecs[k].wmask;
            bus.i_address = vecs[k].i_addr;
            bus.d_address = vecs[k].d_addr;
            bus.d_wdata   = vecs[k].wdata;
            @(negedge clk);
            chk($sformatf("v%0d_idle_strobe", k), {bus.pmem_read, bus.pmem_write}, 2'b00);
            step();
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = vecs[k].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_pmem_read", k), bus.pmem_read, vecs[k].exp_rd);
            chk($sformatf("v%0d_pmem_write", k), bus.pmem_write, vecs[k].exp_wr);
            chk($sformatf("v%0d_addr", k), bus.pmem_address, vecs[k].exp_addr);
            chk($sformatf("v%0d_mask", k), bus.pmem_wmask, vecs[k].exp_mask);
            if (vecs[k].exp_wr) chk($sformatf("v%0d_wdata", k), bus.pmem_wdata, vecs[k].exp_wdata);
            chk($sformatf("v%0d_i_resp", k), bus.i_resp, !vecs[k].exp_owner_d);
            chk($sformatf("v%0d_d_resp", k), bus.d_resp, vecs[k].exp_owner_d);
            if (vecs[k].exp_owner_d) begin
                chk($sformatf("v%0d_d_rdata", k), bus.d_rdata, vecs[k].rdata);
                exp_d++;
            end else begin
                chk($sformatf("v%0d_i_rdata", k), bus.i_rdata, vecs[k].rdata);
                exp_i++;
            end
            step();
            idle_inputs();
        end
        @(negedge clk);
        chk("table_i_count", bus.i_count, exp_i);
        chk("table_d_count", bus.d_count, exp_d);
        step();

        // ---------------- 3-cycle memory latency ----------------
        do_reset();
        bus.i_read    = 1'b1;
        bus.i_address = 16'h0010;
        @(negedge clk);
        chk("lat_no_strobe_yet", bus.pmem_read, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = 16'h1234;
            end
            @(negedge clk);
            chk($sformatf("lat_c%0d_pmem_read", k), bus.pmem_read, 1'b1);
            chk($sformatf("lat_c%0d_addr", k), bus.pmem_address, 16'h0010);
            chk($sformatf("lat_c%0d_i_resp", k), bus.i_resp, (k == 2));
            chk($sformatf("lat_c%0d_d_resp", k), bus.d_resp, 1'b0);
            if (k == 2) chk("lat_i_rdata", bus.i_rdata, 16'h1234);
            step();
        end
        idle_inputs();
        @(negedge clk);
        chk("lat_after_read", bus.pmem_read, 1'b0);
        chk("lat_after_i_resp", bus.i_resp, 1'b0);
        chk("lat_i_count", bus.i_count, 1);
        step();

        // ---------------- continuous contention ----------------
        do_reset();
        bus.i_read    = 1'b1;
        bus.i_address = 16'h0100;
        bus.d_read    = 1'b1;
        bus.d_address = 16'h0200;
        owners.delete();
        wcnt = 0;
        n_resp = 0;
        resp_cycle = -1;
        prev_strobe = 1'b0;
        for (int cyc = 0; cyc < 60 && n_resp < 4; cyc++) begin
            if (bus.pmem_read | bus.pmem_write) begin
                wcnt++;
                bus.pmem_resp  = (wcnt == 2);
                bus.pmem_rdata = bus.pmem_address ^ 16'h5A5A;
            end else begin
                wcnt = 0;
                bus.pmem_resp = 1'b0;
            end
            @(negedge clk);
            if ((bus.pmem_read | bus.pmem_write) && !prev_strobe && resp_cycle >= 0)
                chk($sformatf("cont_gap_%0d", n_resp), cyc - resp_cycle, 2);
            prev_strobe = bus.pmem_read | bus.pmem_write;
            if (bus.i_resp | bus.d_resp) begin
                owners.push_back(bus.d_resp ? 1 : 0);
                resp_cycle = cyc;
                n_resp++;
            end
            step();
        end
        chk("cont_completed", n_resp, 4);
        for (int k = 0; k < owners.size(); k++)
            chk($sformatf("cont_owner_%0d", k), owners[k], k % 2);
        idle_inputs();
        @(negedge clk);
        chk("cont_i_count", bus.i_count, 2);
        chk("cont_d_count", bus.d_count, 2);
        step();

        // ---------------- request changed/dropped mid-grant ----------------
        do_reset();
        bus.i_read    = 1'b1;
        bus.i_address = 16'h0020;
        step();
        bus.i_read    = 1'b0;
        bus.i_address = 16'h0040;
        @(negedge clk);
        chk("mid_addr_held", bus.pmem_address, 16'h0020);
        chk("mid_read_held", bus.pmem_read, 1'b1);
        step();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h7777;
        @(negedge clk);
        chk("mid_addr_resp", bus.pmem_address, 16'h0020);
        chk("mid_i_resp", bus.i_resp, 1'b1);
        chk("mid_i_rdata", bus.i_rdata, 16'h7777);
        step();
        bus.pmem_resp = 1'b0;
        @(negedge clk);
        chk("mid_strobe_done", bus.pmem_read, 1'b0);
        chk("mid_i_count", bus.i_count, 1);
        step();

        // ---------------- reset during a data grant ----------------
        do_reset();
        bus.d_read    = 1'b1;
        bus.d_address = 16'h0300;
        step();
        @(negedge clk);
        chk("rst_mid_strobe_before", bus.pmem_read, 1'b1);
        step();
        reset = 1'b1;
        bus.d_read = 1'b0;
        #1;
        chk("rst_mid_strobe_drop", bus.pmem_read, 1'b0);
        chk("rst_mid_wmask", bus.pmem_wmask, 2'b11);
        step();
        reset = 1'b0;
        step();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h9999;
        @(negedge clk);
        chk("rst_late_d_resp", bus.d_resp, 1'b0);
        chk("rst_late_i_resp", bus.i_resp, 1'b0);
        step();
        bus.pmem_resp = 1'b0;
        @(negedge clk);
        chk("rst_late_strobe", {bus.pmem_read, bus.pmem_write}, 2'b00);
        chk("rst_late_d_count", bus.d_count, 0);
        chk("rst_late_i_count", bus.i_count, 0);
        step();

        // ---------------- counter saturation ----------------
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            bus.d_write   = 1'b1;
            bus.d_wmask   = 2'b11;
            bus.d_address = 16'(n);
            step();
            bus.pmem_resp = 1'b1;
            @(negedge clk);
            chk($sformatf("sat_d_resp_%0d", n), bus.d_resp, 1'b1);
            step();
            bus.d_write   = 1'b0;
            bus.pmem_resp = 1'b0;
            @(negedge clk);
            chk($sformatf("sat_d_count_%0d", n), bus.d_count, (n < CMAX) ? n : CMAX);
        end
        chk("sat_i_count", bus.i_count, 0);
        step();

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        m_busy = 1'b0; m_owner_d = 1'b0; m_last_d = 1'b1;
        m_addr = '0; m_wdata = '0; m_mask = 2'b11; m_write = 1'b0;
        m_icnt = 0; m_dcnt = 0;
        i_act = 1'b0; d_act = 1'b0; i_got = 1'b0; d_got = 1'b0;
        mem_wait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // instruction requester
            if (i_got) begin
                bus.i_read = 1'b0; i_act = 1'b0;
            end else if (!i_act && ($urandom % 3 == 0)) begin
                bus.i_read = 1'b1; i_act = 1'b1;
                bus.i_address = 16'($urandom);
            end else if (i_act && ($urandom % 8 == 0)) begin
                bus.i_address = 16'($urandom);
            end
            // data requester
            if (d_got) begin
                bus.d_read = 1'b0; bus.d_write = 1'b0; d_act = 1'b0;
            end else if (!d_act && ($urandom % 3 == 0)) begin
                int t;
                int mk;
                t = $urandom_range(0, 2);
                mk = $urandom_range(0, 2);
                bus.d_read  = (t != 1);
                bus.d_write = (t != 0);
                bus.d_wmask = (mk == 0) ? 2'b11 : (mk == 1) ? 2'b01 : 2'b10;
                bus.d_address = 16'($urandom);
                bus.d_wdata   = 16'($urandom);
                d_act = 1'b1;
            end else if (d_act && ($urandom % 8 == 0)) begin
                bus.d_address = 16'($urandom);
                bus.d_wdata   = 16'($urandom);
            end
            // memory
            bus.pmem_rdata = 16'($urandom);
            if (bus.pmem_read | bus.pmem_write) begin
                if (mem_wait == 0) bus.pmem_resp = 1'b1;
                else begin
                    bus.pmem_resp = 1'b0;
                    mem_wait--;
                end
            end else begin
                bus.pmem_resp = ($urandom % 8 == 0);
                mem_wait = $urandom_range(0, 3);
            end

            @(negedge clk);
            chk("rnd_pmem_read", bus.pmem_read, m_busy && !m_write);
            chk("rnd_pmem_write", bus.pmem_write, m_busy && m_write);
            if (m_busy) begin
                chk("rnd_addr", bus.pmem_address, m_addr);
                chk("rnd_mask", bus.pmem_wmask, m_mask);
                if (m_write) chk("rnd_wdata", bus.pmem_wdata, m_wdata);
            end
            chk("rnd_i_resp", bus.i_resp, m_busy && !m_owner_d && bus.pmem_resp);
            chk("rnd_d_resp", bus.d_resp, m_busy && m_owner_d && bus.pmem_resp);
            if (bus.i_resp) chk("rnd_i_rdata", bus.i_rdata, bus.pmem_rdata);
            if (bus.d_resp) chk("rnd_d_rdata", bus.d_rdata, bus.pmem_rdata);
            chk("rnd_i_count", bus.i_count, m_icnt);
            chk("rnd_d_count", bus.d_count, m_dcnt);
            i_got = bus.i_resp;
            d_got = bus.d_resp;

            // model: retire the open transaction, or pick the next one from idle
            if (m_busy) begin
                if (bus.pmem_resp) begin
                    m_busy = 1'b0;
                    if (m_owner_d) m_dcnt = sat_inc(m_dcnt);
                    else m_icnt = sat_inc(m_icnt);
                end
            end else if (bus.i_read || bus.d_read || bus.d_write) begin
                logic ir, dr;
                ir = bus.i_read;
                dr = bus.d_read | bus.d_write;
                m_owner_d = (ir && dr) ? !m_last_d : dr;
                m_last_d  = m_owner_d;
                m_busy    = 1'b1;
                if (m_owner_d) begin
                    m_addr = bus.d_address; m_wdata = bus.d_wdata;
                    m_mask = bus.d_wmask;   m_write = bus.d_write;
                end else begin
                    m_addr = bus.i_address; m_wdata = '0;
                    m_mask = 2'b11;         m_write = 1'b0;
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
